// File: rtl/grid_render_engine.sv
// Grid-to-pixel renderer: double-buffered cell grid, palette, grid lines and cursor ring, 2-cycle
// pixel latency. Define GRID_CURSOR_BLINK_EN to blink the cursor every 2^BLINK_LOG2 frames.
module grid_render_engine #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned CELL_BITS    = 5,
  parameter int unsigned CELL_LOG2    = 4,
  parameter int unsigned ORIGIN_X     = 2,
  parameter int unsigned ORIGIN_Y     = 17,
  parameter logic [15:0] BG_COLOR     = 16'h0000,
  parameter logic [15:0] LINE_COLOR   = 16'h8410,
  parameter logic [15:0] CURSOR_COLOR = 16'hFFE0,
  parameter logic [127:0] PALETTE     = 128'h7BEF_F81F_07FF_FD20_FFE0_001F_07E0_F800,
  parameter int unsigned BLINK_LOG2   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ROWS*COLS*CELL_BITS-1:0]  grid_in,
  input  logic                            grid_valid,
  input  logic                            frame_sync,
  input  logic [7:0]                      pix_x,
  input  logic [7:0]                      pix_y,
  input  logic                            cursor_en,
  input  logic [$clog2(ROWS)-1:0]         cursor_row,
  input  logic [$clog2(COLS)-1:0]         cursor_col,
  output logic [15:0]                     pix_data,
  output logic                            swap_pending
);

  localparam int unsigned RowW     = $clog2(ROWS);
  localparam int unsigned ColW     = $clog2(COLS);
  localparam int unsigned GridW    = COLS << CELL_LOG2;
  localparam int unsigned GridH    = ROWS << CELL_LOG2;
  localparam int unsigned CellPx   = 1 << CELL_LOG2;
  localparam int unsigned GridBits = ROWS * COLS * CELL_BITS;

  logic [GridBits-1:0]  staging_q, staging_d;
  logic [GridBits-1:0]  display_q, display_d;
  logic                 swap_pending_q, swap_pending_d;

  logic [8:0]           dx, dy;
  logic                 inside_q, inside_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [ColW-1:0]      col_q, col_d;
  logic [CELL_LOG2-1:0] ox_q, ox_d;
  logic [CELL_LOG2-1:0] oy_q, oy_d;

  logic [15:0]          pix_q, pix_d;
  logic                 cursor_vis;

  int unsigned          cell_idx;
  logic [CELL_BITS-1:0] cell_val;
  logic                 on_line, on_ring, cursor_hit;

`ifdef GRID_CURSOR_BLINK_EN
  logic [BLINK_LOG2:0]  frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_sync) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign cursor_vis = cursor_en & ~frame_cnt_q[BLINK_LOG2];
`else
  assign cursor_vis = cursor_en;
`endif

  // Display swaps only at frame start, taking the staging content from before this cycle.
  always_comb begin
    staging_d      = staging_q;
    display_d      = display_q;
    swap_pending_d = swap_pending_q;
    if (frame_sync && swap_pending_q) begin
      display_d      = staging_q;
      swap_pending_d = 1'b0;
    end
    if (grid_valid) begin
      staging_d      = grid_in;
      swap_pending_d = 1'b1;
    end
  end

  // Stage 1: pixel address to cell coordinates and in-cell offsets.
  always_comb begin
    dx       = {1'b0, pix_x} - 9'(ORIGIN_X);
    dy       = {1'b0, pix_y} - 9'(ORIGIN_Y);
    inside_d = ~dx[8] & ~dy[8] & (dx < 9'(GridW)) & (dy < 9'(GridH));
    col_d    = '0;
    row_d    = '0;
    if (inside_d) begin
      col_d = ColW'(dx >> CELL_LOG2);
      row_d = RowW'(dy >> CELL_LOG2);
    end
    ox_d = dx[CELL_LOG2-1:0];
    oy_d = dy[CELL_LOG2-1:0];
  end

  // Stage 2: colour selection in priority order.
  always_comb begin
    cell_idx   = 32'(row_q) * COLS + 32'(col_q);
    cell_val   = display_q[cell_idx*CELL_BITS +: CELL_BITS];
    on_line    = (ox_q == '0) || (oy_q == '0) ||
                 ((col_q == ColW'(COLS - 1)) && (ox_q == '1)) ||
                 ((row_q == RowW'(ROWS - 1)) && (oy_q == '1));
    on_ring    = (ox_q == CELL_LOG2'(1)) || (ox_q == CELL_LOG2'(CellPx - 2)) ||
                 (oy_q == CELL_LOG2'(1)) || (oy_q == CELL_LOG2'(CellPx - 2));
    cursor_hit = cursor_vis && (row_q == cursor_row) && (col_q == cursor_col) && on_ring;

    if (!inside_q)             pix_d = BG_COLOR;
    else if (on_line)          pix_d = LINE_COLOR;
    else if (cursor_hit)       pix_d = CURSOR_COLOR;
    else if (cell_val == '0)   pix_d = BG_COLOR;
    else                       pix_d = PALETTE[{cell_val[2:0], 4'b0000} +: 16];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      staging_q      <= '0;
      display_q      <= '0;
      swap_pending_q <= 1'b0;
      inside_q       <= 1'b0;
      row_q          <= '0;
      col_q          <= '0;
      ox_q           <= '0;
      oy_q           <= '0;
      pix_q          <= '0;
    end else begin
      staging_q      <= staging_d;
      display_q      <= display_d;
      swap_pending_q <= swap_pending_d;
      inside_q       <= inside_d;
      row_q          <= row_d;
      col_q          <= col_d;
      ox_q           <= ox_d;
      oy_q           <= oy_d;
      pix_q          <= pix_d;
    end
  end

  assign pix_data     = pix_q;
  assign swap_pending = swap_pending_q;

endmodule

// File: tb/tb_grid_render_engine.sv
// Self-checking bench for grid_render_engine: vector table, hand sequences for buffering, latency,
// blink and reset, plus randomized pixel bursts against a behavioural grid model.
module tb_grid_render_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CB   = 5;
  localparam int CL   = 4;
  localparam int CELL = 16;
  localparam int OX   = 2;
  localparam int OY   = 17;
  localparam int GB   = ROWS * COLS * CB;
  localparam logic [15:0]  BG   = 16'h0000;
  localparam logic [15:0]  LINE = 16'h8410;
  localparam logic [15:0]  CUR  = 16'hFFE0;
  localparam logic [127:0] PAL_PACKED = 128'h7BEF_F81F_07FF_FD20_FFE0_001F_07E0_F800;

  logic [15:0] pal [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
                           16'hFD20, 16'h07FF, 16'hF81F, 16'h7BEF};

  logic          clk, rst;
  logic [GB-1:0] grid_in;
  logic          grid_valid, frame_sync, cursor_en;
  logic [7:0]    pix_x, pix_y;
  logic [2:0]    cursor_row, cursor_col;
  logic [15:0]   pix_data;
  logic          swap_pending;

  grid_render_engine #(
    .ROWS(ROWS), .COLS(COLS), .CELL_BITS(CB), .CELL_LOG2(CL), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .BG_COLOR(BG), .LINE_COLOR(LINE), .CURSOR_COLOR(CUR), .PALETTE(PAL_PACKED), .BLINK_LOG2(4)
  ) dut (
    .clk(clk), .rst(rst), .grid_in(grid_in), .grid_valid(grid_valid), .frame_sync(frame_sync),
    .pix_x(pix_x), .pix_y(pix_y), .cursor_en(cursor_en), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .pix_data(pix_data), .swap_pending(swap_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  int nxt  [ROWS][COLS];
  int stg  [ROWS][COLS];
  int disp [ROWS][COLS];
  bit pend;
  int fcnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int          x;
    int          y;
    bit          ce;
    int          cr;
    int          cc;
    logic [15:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        stg[r][c]  = 0;
        disp[r][c] = 0;
      end
    pend = 0;
    fcnt = 0;
  endtask

  task automatic clear_nxt();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) nxt[r][c] = 0;
  endtask

  function automatic logic [GB-1:0] pack_nxt();
    logic [GB-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[(r*COLS+c)*CB +: CB] = CB'(nxt[r][c]);
    return v;
  endfunction

  function automatic bit ref_vis();
`ifdef GRID_CURSOR_BLINK_EN
    return cursor_en && ((fcnt / 16) % 2 == 0);
`else
    return cursor_en;
`endif
  endfunction

  function automatic logic [15:0] ref_pix(input int x, input int y, input bit vis,
                                          input int cr, input int cc);
    int dx, dy, r, c, ox, oy, v;
    dx = x - OX;
    dy = y - OY;
    if (dx < 0 || dy < 0 || dx >= COLS * CELL || dy >= ROWS * CELL) return BG;
    c  = dx / CELL;
    r  = dy / CELL;
    ox = dx % CELL;
    oy = dy % CELL;
    if (ox == 0 || oy == 0 || dx == COLS * CELL - 1 || dy == ROWS * CELL - 1) return LINE;
    if (vis && r == cr && c == cc && (ox == 1 || ox == CELL - 2 || oy == 1 || oy == CELL - 2))
      return CUR;
    v = disp[r][c];
    if (v == 0) return BG;
    return pal[v % 8];
  endfunction

  // One cycle of buffer control, mirrored in the model, then swap_pending is checked.
  task automatic pulse(input bit gv, input bit fs);
    grid_valid = gv;
    frame_sync = fs;
    if (gv) grid_in = pack_nxt();
    step();
    grid_valid = 1'b0;
    frame_sync = 1'b0;
    if (fs && pend) disp = stg;
    if (gv) begin
      stg  = nxt;
      pend = 1;
    end else if (fs) begin
      pend = 0;
    end
    if (fs) fcnt = (fcnt + 1) % 32;
    check("swap_pending", {15'd0, swap_pending}, {15'd0, pend});
  endtask

  task automatic probe(input string nm, input int x, input int y, input logic [15:0] exp);
    pix_x = 8'(x);
    pix_y = 8'(y);
    step();
    step();
    check(nm, pix_data, exp);
  endtask

  task automatic rand_burst(input int n);
    logic [15:0] ex[$];
    int x, y;
    cursor_en  = 1'($urandom_range(0, 3) != 0);
    cursor_row = 3'($urandom_range(0, 7));
    cursor_col = 3'($urandom_range(0, 7));
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        case ($urandom_range(0, 3))
          0: begin
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
          end
          1: begin
            x = $urandom_range(0, 135);
            y = $urandom_range(10, 150);
          end
          default: begin
            x = OX + int'(cursor_col) * CELL + $urandom_range(0, CELL - 1);
            y = OY + int'(cursor_row) * CELL + $urandom_range(0, CELL - 1);
          end
        endcase
        pix_x = 8'(x);
        pix_y = 8'(y);
        ex.push_back(ref_pix(x, y, ref_vis(), int'(cursor_row), int'(cursor_col)));
      end
      step();
      if (i >= 1) check("random_pixel", pix_data, ex.pop_front());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; grid_in = '0; grid_valid = 1'b0; frame_sync = 1'b0;
    pix_x = '0; pix_y = '0; cursor_en = 1'b0; cursor_row = '0; cursor_col = '0;
    model_reset();
    clear_nxt();
    step();
    step();
    check("reset_pix_data", pix_data, 16'h0000);
    check("reset_swap_pending", {15'd0, swap_pending}, 16'd0);
    rst = 1'b0;

    // Swap gating and exact latency.
    nxt[0][0] = 1;
    pulse(1, 0);
    probe("gate_before_swap", 10, 25, BG);
    check("gate_still_pending", {15'd0, swap_pending}, 16'd1);
    pulse(0, 1);
    probe("latency_prev_addr", 1, 17, BG);
    pix_x = 8'd10;
    pix_y = 8'd25;
    step();
    check("latency_not_1", pix_data, BG);
    step();
    check("latency_2", pix_data, pal[1]);

    // Collision: new grid_valid coincident with frame_sync.
    nxt[0][0] = 2;
    pulse(1, 0);
    nxt[0][0] = 3;
    pulse(1, 1);
    probe("collide_shows_A", 10, 25, pal[2]);
    pulse(0, 1);
    probe("collide_then_B", 10, 25, pal[3]);

    // Repeated grid_valid: last wins.
    nxt[0][0] = 4;
    pulse(1, 0);
    nxt[0][0] = 5;
    pulse(1, 0);
    pulse(0, 1);
    probe("last_wins", 10, 25, pal[5]);

    // Vector table on a known grid.
    clear_nxt();
    nxt[0][0] = 1;
    nxt[1][1] = 10;
    nxt[7][7] = 7;
    nxt[4][5] = 8;
    pulse(1, 0);
    pulse(0, 1);
    tbl.push_back('{1,   17,  0, 0, 0, BG,             "left_of_grid"});
    tbl.push_back('{130, 17,  0, 0, 0, BG,             "right_of_grid"});
    tbl.push_back('{2,   17,  0, 0, 0, LINE,           "origin_line"});
    tbl.push_back('{18,  30,  0, 0, 0, LINE,           "inner_line"});
    tbl.push_back('{131, 20,  0, 0, 0, BG,             "dx_129"});
    tbl.push_back('{10,  25,  0, 0, 0, 16'h07E0,       "cell00_pal1"});
    tbl.push_back('{51,  54,  1, 2, 3, CUR,            "cursor_ring"});
    tbl.push_back('{55,  54,  1, 2, 3, BG,             "cursor_interior"});
    tbl.push_back('{26,  41,  0, 0, 0, 16'h001F,       "value10_low_bits"});
    tbl.push_back('{129, 100, 0, 0, 0, LINE,           "last_column"});
    tbl.push_back('{100, 144, 0, 0, 0, LINE,           "last_row"});
    tbl.push_back('{122, 137, 0, 0, 0, 16'h7BEF,       "cell77_pal7"});
    tbl.push_back('{90,  89,  0, 0, 0, 16'hF800,       "value8_pal0"});
    tbl.push_back('{32,  41,  1, 1, 1, CUR,            "cursor_over_value"});
    tbl.push_back('{26,  41,  1, 1, 1, 16'h001F,       "cursor_cell_inner"});
    tbl.push_back('{50,  54,  1, 2, 3, LINE,           "line_over_cursor"});
    tbl.push_back('{255, 255, 0, 0, 0, BG,             "far_corner"});
    tbl.push_back('{0,   0,   1, 0, 0, BG,             "zero_corner"});
    foreach (tbl[i]) begin
      cursor_en  = tbl[i].ce;
      cursor_row = 3'(tbl[i].cr);
      cursor_col = 3'(tbl[i].cc);
      probe(tbl[i].nm, tbl[i].x, tbl[i].y, tbl[i].exp);
    end

    // Blink phases relative to the frame counter.
    cursor_en  = 1'b1;
    cursor_row = 3'd2;
    cursor_col = 3'd3;
    for (int k = 0; k < 32 && fcnt != 16; k++) pulse(0, 1);
`ifdef GRID_CURSOR_BLINK_EN
    probe("blink_off_phase", 51, 54, BG);
`else
    probe("blink_off_phase", 51, 54, CUR);
`endif
    repeat (16) pulse(0, 1);
    probe("blink_on_phase", 51, 54, CUR);

    // Randomized grids, buffer traffic and pixel bursts.
    repeat (8) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          nxt[r][c] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 31);
      pulse(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      rand_burst(60);
    end

    // Reset asserted between addresses with a pending grid.
    clear_nxt();
    nxt[0][0] = 1;
    pulse(1, 0);
    pulse(0, 1);
    nxt[0][0] = 2;
    pulse(1, 0);
    pix_x = 8'd10;
    pix_y = 8'd25;
    step();
    rst = 1'b1;
    step();
    model_reset();
    check("midreset_pix_data", pix_data, 16'h0000);
    check("midreset_swap_pending", {15'd0, swap_pending}, 16'd0);
    rst = 1'b0;
    probe("reset_display_cleared", 10, 25, BG);
    pulse(0, 1);
    probe("reset_staging_cleared", 10, 25, BG);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/grid_render_engine.md
Name: grid_render_engine

Overview:
Parametrised pixel generator between the game-model grid state and the SPI LCD driver's pixel-address interface. It supports any ROWS x COLS grid with power-of-two cell size and programmable origin. The grid snapshot is double-buffered and only swapped at frame start, so frames never tear. It adds a palette lookup, grid lines and a cursor overlay. Pixel data is returned with a fixed 2-cycle latency for the driver's read-ahead.

Parameters:
- ROWS, 8, grid rows
- COLS, 8, grid columns
- CELL_BITS, 5, bits per cell value
- CELL_LOG2, 4, log2 of cell edge in pixels (16 px)
- ORIGIN_X, 2, first grid pixel column
- ORIGIN_Y, 17, first grid pixel row
- BG_COLOR, 16'h0000, RGB565 outside the grid
- LINE_COLOR, 16'h8410, RGB565 for grid lines
- CURSOR_COLOR, 16'hFFE0, RGB565 for the cursor ring
- PALETTE, 128'h...(8x16), packed RGB565; entry i = bits [16i+15:16i]
- BLINK_LOG2, 4, blink half-period = 2^BLINK_LOG2 frames

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- grid_in  in  ROWS*COLS*CELL_BITS  cell (r,c) at bits [((r*COLS+c)+1)*CELL_BITS-1 : (r*COLS+c)*CELL_BITS]
- grid_valid  in  1  1-cycle pulse: capture grid_in into staging
- frame_sync  in  1  1-cycle pulse from the LCD driver at frame start
- pix_x  in  8  requested pixel column
- pix_y  in  8  requested pixel row
- cursor_en  in  1  enable cursor overlay
- cursor_row  in  $clog2(ROWS)  cursor row
- cursor_col  in  $clog2(COLS)  cursor column
- pix_data  out  16  RGB565 for the address presented 2 cycles earlier
- swap_pending  out  1  staging holds data not yet displayed

Behaviour:
- Reset: staging=0, display=0, swap_pending=0, frame_cnt=0, pipeline regs cleared, pix_data=16'h0000.
- Buffering:
  - grid_valid: staging<=grid_in; swap_pending<=1.
  - frame_sync with swap_pending=1: display<=staging; swap_pending<=0.
  - frame_sync with swap_pending=0: display unchanged.
  - Simultaneous grid_valid and frame_sync: display takes the OLD staging if pending; staging takes the new grid_in; swap_pending=1.
  - Repeated grid_valid before a swap: the last one wins.
  - The cursor inputs are sampled every cycle; they are not buffered.
- frame_cnt: BLINK_LOG2+1 bits, increments on every frame_sync and wraps.
- Stage 1, registered:
  - dx=pix_x-ORIGIN_X, dy=pix_y-ORIGIN_Y, both 9-bit signed.
  - inside = dx>=0 && dy>=0 && dx<COLS<<CELL_LOG2 && dy<ROWS<<CELL_LOG2.
  - col=dx>>CELL_LOG2, row=dy>>CELL_LOG2.
  - ox=dx[CELL_LOG2-1:0], oy=dy[CELL_LOG2-1:0].
- Stage 2, registered into pix_data, in priority order:
  - !inside -> BG_COLOR.
  - ox==0 or oy==0, or the pixel is the last column/row of the grid -> LINE_COLOR.
  - cursor_vis, cell==cursor, and (ox or oy == 1 or CELL-2) -> CURSOR_COLOR.
  - value==0 -> BG_COLOR.
  - Otherwise -> PALETTE[value[2:0]]. Value bits above bit 2 are ignored.
- Latency: exactly 2 cycles with no stalls. Back-to-back addresses are accepted every cycle.
- Reset asserted mid-frame: pipeline flushed; pix_data=0 on the cycle after reset.

Optional Feature:
- Macro: GRID_CURSOR_BLINK_EN.
- Defined: cursor_vis = cursor_en & ~frame_cnt[BLINK_LOG2].
- Undefined: cursor_vis = cursor_en, frame_cnt is not instantiated, and the cursor is steady.

Test Plan:
- Swap gating: grid_valid with cell(0,0)=1, then pix(10,25) -> pix_data stays 0; swap_pending=1 until frame_sync; after the swap, pix_data=PALETTE[1] exactly 2 cycles after the address.
- Geometry: pix(1,17), pix(130,17) -> BG_COLOR. pix(2,17), pix(18,30) -> LINE_COLOR. pix(131,20) -> BG_COLOR, because dx=129 is outside the grid.
- Collision: grid_valid(A), then grid_valid(B) coincident with frame_sync -> display=A, swap_pending=1. The next frame_sync -> display=B.
- Cursor: cursor_en=1, row=2, col=3, cell empty. pix(2+48+1, 17+32+5) -> CURSOR_COLOR. pix(2+48+5, 17+32+5) -> BG_COLOR.
- Blink, macro defined: 16 frame_syncs -> the cursor pixel toggles to BG_COLOR; after 32 frame_syncs it shows CURSOR_COLOR again. Macro undefined: always CURSOR_COLOR.
- Reset: reset asserted between addresses -> pix_data=0, swap_pending=0, display cleared; any cell reads BG_COLOR afterwards.
